// File: rtl/add4_pkg.sv
// Shared definitions for the add4_accum batch accumulator: state encoding,
// data width and carry-count saturation value.
package add4_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0] CARRY_SAT = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fulladd4.sv
// 4-bit full adder: {C_OUT, SUM} = A + B + C_IN.
module fulladd4
  import add4_pkg::*;
(
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              C_IN,
  output logic [DATA_W-1:0] SUM,
  output logic              C_OUT
);

  // Plain ripple add with one extra bit to capture the carry out
  always_comb begin
    {C_OUT, SUM} = (DATA_W+1)'(A) + (DATA_W+1)'(B) + (DATA_W+1)'(C_IN);
  end

endmodule

// File: rtl/add4_accum.sv
// Batch accumulator driving fulladd4: sums N_OPS operands per batch, counts
// carry-out events, and presents the result over a valid/ready handshake.
// Build option: define ADD4_ACCUM_SAT_EN to clamp the accumulator to 4'hF
// on the first carry of a batch instead of wrapping mod 16.
module add4_accum
  import add4_pkg::*;
#(
  parameter int unsigned N_OPS = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              CLR,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_SUM,
  output logic [CNT_W-1:0]  OUT_CARRY_CNT,
  output logic              OUT_OVF
);

  localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(N_OPS - 1);

  state_t              state;
  logic [DATA_W-1:0]   acc;
  logic [CNT_W-1:0]    op_cnt;
  logic [CNT_W-1:0]    carry_cnt;
  logic                in_ready_q;
  logic                out_valid_q;

  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;
  logic [DATA_W-1:0]   acc_next;

  fulladd4 u_fulladd4 (
    .A     (acc),
    .B     (IN_DATA),
    .C_IN  (1'b0),
    .SUM   (add_sum),
    .C_OUT (add_cout)
  );

  // New accumulator value for an accepted operand (wrap or clamp)
  always_comb begin
    acc_next = add_sum;
`ifdef ADD4_ACCUM_SAT_EN
    if (add_cout) begin
      acc_next = DATA_W'(CARRY_SAT);
    end
`endif
  end

  // Batch FSM with registered handshake outputs; CLR overrides everything
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= ST_IDLE;
      acc         <= '0;
      op_cnt      <= '0;
      carry_cnt   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (CLR) begin
      state       <= ST_IDLE;
      acc         <= '0;
      op_cnt      <= '0;
      carry_cnt   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (START) begin
            state      <= ST_ACCUM;
            acc        <= '0;
            op_cnt     <= '0;
            carry_cnt  <= '0;
            in_ready_q <= 1'b1;
          end
        end
        ST_ACCUM: begin
          if (IN_VALID && in_ready_q) begin
            acc    <= acc_next;
            op_cnt <= op_cnt + CNT_W'(1);
            if (add_cout && (carry_cnt != CARRY_SAT)) begin
              carry_cnt <= carry_cnt + CNT_W'(1);
            end
            if (op_cnt == LAST_OP) begin
              state       <= ST_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (OUT_READY) begin
            state       <= ST_ACCUM;
            acc         <= '0;
            op_cnt      <= '0;
            carry_cnt   <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign IN_READY      = in_ready_q;
  assign OUT_VALID     = out_valid_q;
  assign OUT_SUM       = acc;
  assign OUT_CARRY_CNT = carry_cnt;
  assign OUT_OVF       = (carry_cnt != '0);

endmodule

// File: tb/tb_add4_accum.sv
// Directed plus randomized bench for add4_accum with an arithmetic
// reference model of a whole batch.
module tb_add4_accum;

  localparam int unsigned N = 4;

  logic       CLK;
  logic       RST_N;
  logic       START;
  logic       CLR;
  logic       IN_VALID;
  logic       IN_READY;
  logic [3:0] IN_DATA;
  logic       OUT_VALID;
  logic       OUT_READY;
  logic [3:0] OUT_SUM;
  logic [3:0] OUT_CARRY_CNT;
  logic       OUT_OVF;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] exp_sum;
  logic [3:0] exp_cnt;

  add4_accum #(.N_OPS(N)) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .START         (START),
    .CLR           (CLR),
    .IN_VALID      (IN_VALID),
    .IN_READY      (IN_READY),
    .IN_DATA       (IN_DATA),
    .OUT_VALID     (OUT_VALID),
    .OUT_READY     (OUT_READY),
    .OUT_SUM       (OUT_SUM),
    .OUT_CARRY_CNT (OUT_CARRY_CNT),
    .OUT_OVF       (OUT_OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: whole-batch result from plain arithmetic on the operand list
  function automatic void model(input logic [3:0] d[N], output logic [3:0] s,
                                output logic [3:0] c);
    int tot;
    int n;
    tot = 0;
    n   = 0;
`ifdef ADD4_ACCUM_SAT_EN
    for (int i = 0; i < int'(N); i++) begin
      tot = tot + int'(d[i]);
      if (tot > 15) begin
        n++;
        tot = 15;
      end
    end
    s = 4'(tot);
`else
    for (int i = 0; i < int'(N); i++) tot = tot + int'(d[i]);
    s = 4'(tot % 16);
    n = tot / 16;
`endif
    if (n > 15) n = 15;
    c = 4'(n);
  endfunction

  task automatic send(input logic [3:0] d);
    IN_VALID = 1'b1;
    IN_DATA  = d;
    tick();
    IN_VALID = 1'b0;
    IN_DATA  = 4'($urandom_range(0, 15));
  endtask

  task automatic idle_cycles(input int n);
    IN_VALID = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
    check("start_in_ready", 8'(IN_READY), 8'd1);
  endtask

  // Feed one full batch (block must be in ACCUM) and check the result
  task automatic batch(input logic [3:0] d[N], input int max_gap);
    model(d, exp_sum, exp_cnt);
    for (int i = 0; i < int'(N); i++) begin
      idle_cycles($urandom_range(0, max_gap));
      if (i == int'(N) - 1) check("pre_out_valid", 8'(OUT_VALID), 8'd0);
      send(d[i]);
    end
    check("out_valid", 8'(OUT_VALID), 8'd1);
    check("done_in_ready", 8'(IN_READY), 8'd0);
    check("out_sum", 8'(OUT_SUM), 8'(exp_sum));
    check("out_carry_cnt", 8'(OUT_CARRY_CNT), 8'(exp_cnt));
    check("out_ovf", 8'(OUT_OVF), 8'(exp_cnt != 4'd0));
  endtask

  // Stall in DONE, then complete the output handshake
  task automatic handshake(input int stall);
    OUT_READY = 1'b0;
    repeat (stall) begin
      tick();
      check("stall_valid", 8'(OUT_VALID), 8'd1);
      check("stall_sum", 8'(OUT_SUM), 8'(exp_sum));
      check("stall_cnt", 8'(OUT_CARRY_CNT), 8'(exp_cnt));
      check("stall_in_ready", 8'(IN_READY), 8'd0);
    end
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    check("hs_out_valid", 8'(OUT_VALID), 8'd0);
    check("hs_in_ready", 8'(IN_READY), 8'd1);
    check("hs_acc_clear", 8'(OUT_SUM), 8'd0);
    check("hs_cnt_clear", 8'(OUT_CARRY_CNT), 8'd0);
  endtask

  initial begin
    logic [3:0] d[N];

    RST_N     = 1'b0;
    START     = 1'b0;
    CLR       = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = 4'd0;
    OUT_READY = 1'b0;
    exp_sum   = 4'd0;
    exp_cnt   = 4'd0;

    // Reset values
    repeat (2) tick();
    check("rst_in_ready", 8'(IN_READY), 8'd0);
    check("rst_out_valid", 8'(OUT_VALID), 8'd0);
    check("rst_out_sum", 8'(OUT_SUM), 8'd0);
    check("rst_carry_cnt", 8'(OUT_CARRY_CNT), 8'd0);
    check("rst_ovf", 8'(OUT_OVF), 8'd0);
    RST_N = 1'b1;
    tick();
    check("idle_in_ready", 8'(IN_READY), 8'd0);

    // 1,2,3,4 -> 10, no carries
    do_start();
    d = '{4'd1, 4'd2, 4'd3, 4'd4};
    batch(d, 0);
    check("dir1_sum", 8'(OUT_SUM), 8'ha);
    handshake(5);

    // 4,5,6,7 -> wrap 6 / clamp 15, one carry; no START needed
    d = '{4'd4, 4'd5, 4'd6, 4'd7};
    batch(d, 0);
`ifdef ADD4_ACCUM_SAT_EN
    check("dir2_sum", 8'(OUT_SUM), 8'hf);
`else
    check("dir2_sum", 8'(OUT_SUM), 8'd6);
`endif
    check("dir2_cnt", 8'(OUT_CARRY_CNT), 8'd1);
    handshake(0);

    // IN_VALID pattern 1,0,0,1,1,0,1 with data 15
    model('{4'd15, 4'd15, 4'd15, 4'd15}, exp_sum, exp_cnt);
    send(4'd15);
    idle_cycles(2);
    send(4'd15);
    send(4'd15);
    idle_cycles(1);
    check("gap_pre_valid", 8'(OUT_VALID), 8'd0);
    send(4'd15);
    check("gap_valid", 8'(OUT_VALID), 8'd1);
`ifndef ADD4_ACCUM_SAT_EN
    check("gap_sum", 8'(OUT_SUM), 8'd12);
`else
    check("gap_sum", 8'(OUT_SUM), 8'hf);
`endif
    check("gap_cnt", 8'(OUT_CARRY_CNT), 8'd3);
    handshake(1);

    // CLR after two accepts
    send(4'd3);
    send(4'd9);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    check("clr_in_ready", 8'(IN_READY), 8'd0);
    check("clr_sum", 8'(OUT_SUM), 8'd0);
    send(4'd1);
    check("clr_idle_ignores", 8'(OUT_SUM), 8'd0);
    do_start();
    d = '{4'd1, 4'd1, 4'd1, 4'd1};
    batch(d, 0);
    check("clr_then_sum", 8'(OUT_SUM), 8'd4);

    // CLR together with the output handshake: CLR wins
    CLR       = 1'b1;
    OUT_READY = 1'b1;
    tick();
    CLR       = 1'b0;
    OUT_READY = 1'b0;
    check("clr_hs_valid", 8'(OUT_VALID), 8'd0);
    check("clr_hs_in_ready", 8'(IN_READY), 8'd0);

    // START inside ACCUM must not restart the batch
    do_start();
    d = '{4'd2, 4'd3, 4'd5, 4'd1};
    model(d, exp_sum, exp_cnt);
    send(d[0]);
    send(d[1]);
    START = 1'b1;
    tick();
    START = 1'b0;
    send(d[2]);
    send(d[3]);
    check("start_ign_valid", 8'(OUT_VALID), 8'd1);
    check("start_ign_sum", 8'(OUT_SUM), 8'(exp_sum));
    handshake(2);

    // Randomized batches with input gaps and output stalls
    for (int b = 0; b < 25; b++) begin
      for (int i = 0; i < int'(N); i++) d[i] = 4'($urandom_range(0, 15));
      batch(d, 2);
      handshake($urandom_range(0, 3));
    end

    // Asynchronous reset mid-batch
    send(4'd7);
    send(4'd8);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_in_ready", 8'(IN_READY), 8'd0);
    check("arst_sum", 8'(OUT_SUM), 8'd0);
    check("arst_valid", 8'(OUT_VALID), 8'd0);
    tick();
    RST_N = 1'b1;
    tick();
    check("arst_idle", 8'(IN_READY), 8'd0);
    do_start();
    d = '{4'd9, 4'd9, 4'd0, 4'd3};
    batch(d, 1);
    handshake(0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
